// File: rtl/rx_stamp_gen.sv
// Free-running 32.32 timestamp counter plus a passive start-of-packet tap on an AXI4-Stream.
// Define RX_STAMP_PPS_SYNC_EN to round the counter to the nearest second on each pps pulse.
`default_nettype none

module rx_stamp_gen #(
  parameter int                   TIMESTAMP_WIDTH = 64,
  parameter int                   INC_WIDTH       = 32,
  parameter logic [INC_WIDTH-1:0] DEFAULT_INC     = 32'd26843546
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic                       stamp_inc_wr,
  input  logic [INC_WIDTH-1:0]       stamp_inc,
  input  logic                       stamp_load,
  input  logic [TIMESTAMP_WIDTH-1:0] stamp_load_value,
  input  logic                       pps,
  output logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
  output logic                       pkt_start,
  output logic [31:0]                pkt_count
);

  localparam int FRAC_W = 32;
  localparam int SEC_W  = TIMESTAMP_WIDTH - FRAC_W;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } sof_state_e;

  sof_state_e                 state_q, state_d;
  logic [TIMESTAMP_WIDTH-1:0] counter_q, counter_d;
  logic [INC_WIDTH-1:0]       inc_q, inc_d;
  logic                       pkt_start_q, pkt_start_d;
  logic [31:0]                pkt_count_q, pkt_count_d;

  logic beat;
  logic sof;

  assign beat = s_axis_tvalid & s_axis_tready;

  // SOF tracking: a beat seen in FIRST opens a packet unless it is also the last beat.
  always_comb begin
    state_d = state_q;
    sof     = 1'b0;
    case (state_q)
      ST_FIRST: begin
        if (beat) begin
          sof = 1'b1;
          if (!s_axis_tlast) state_d = ST_MID;
        end
      end
      ST_MID: begin
        if (beat && s_axis_tlast) state_d = ST_FIRST;
      end
      default: state_d = ST_FIRST;
    endcase
  end

  always_comb begin
    pkt_start_d = sof;
    pkt_count_d = pkt_count_q + {31'd0, sof};
  end

  // A newly written increment takes effect from the next cycle's addition.
  always_comb begin
    inc_d = inc_q;
    if (stamp_inc_wr) inc_d = stamp_inc;
  end

`ifdef RX_STAMP_PPS_SYNC_EN
  logic [SEC_W-1:0] sec_rounded;
  assign sec_rounded = counter_q[TIMESTAMP_WIDTH-1:FRAC_W] + SEC_W'(counter_q[FRAC_W-1]);

  always_comb begin
    counter_d = counter_q + TIMESTAMP_WIDTH'(inc_q);
    if (stamp_load) begin
      counter_d = stamp_load_value;
    end else if (pps) begin
      counter_d = {sec_rounded, {FRAC_W{1'b0}}};
    end
  end
`else
  logic unused_pps;
  assign unused_pps = pps;

  always_comb begin
    counter_d = counter_q + TIMESTAMP_WIDTH'(inc_q);
    if (stamp_load) counter_d = stamp_load_value;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FIRST;
      counter_q   <= '0;
      inc_q       <= DEFAULT_INC;
      pkt_start_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      inc_q       <= inc_d;
      pkt_start_q <= pkt_start_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign stamp_counter = counter_q;
  assign pkt_start     = pkt_start_q;
  assign pkt_count     = pkt_count_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_stamp_gen.sv
// Scoreboard bench for rx_stamp_gen: a per-cycle arithmetic model feeds expected queues,
// a negedge monitor pops and compares.
module tb_rx_stamp_gen;

  localparam logic [31:0] DEF_INC = 32'd26843546;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic        stamp_inc_wr;
  logic [31:0] stamp_inc;
  logic        stamp_load;
  logic [63:0] stamp_load_value;
  logic        pps;
  logic [63:0] stamp_counter;
  logic        pkt_start;
  logic [31:0] pkt_count;

  rx_stamp_gen dut (
    .clk              (clk),
    .reset            (reset),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tlast     (s_axis_tlast),
    .stamp_inc_wr     (stamp_inc_wr),
    .stamp_inc        (stamp_inc),
    .stamp_load       (stamp_load),
    .stamp_load_value (stamp_load_value),
    .pps              (pps),
    .stamp_counter    (stamp_counter),
    .pkt_start        (pkt_start),
    .pkt_count        (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cnt;
    logic [31:0] pc;
    logic        ps;
  } cyc_t;

  typedef struct {
    int          cyc;
    logic [63:0] stamp;
    logic [31:0] pc;
  } pulse_t;

  cyc_t   sq[$];
  pulse_t pq[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference state: time value, increment, whether a packet is open, packets seen.
  logic [63:0] m_cnt;
  logic [31:0] m_inc;
  bit          m_open;
  logic [31:0] m_pc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc_t   e;
    pulse_t p;
    if (sq.size() > 0) begin
      e = sq.pop_front();
      chk("stamp_counter", stamp_counter, e.cnt);
      chk("pkt_count", {32'd0, pkt_count}, {32'd0, e.pc});
      chk("pkt_start", {63'd0, pkt_start}, {63'd0, e.ps});
    end
    if (pkt_start === 1'b1) begin
      if (pq.size() == 0) begin
        chk("unexpected_pulse", 64'd1, 64'd0);
      end else begin
        p = pq.pop_front();
        chk("pulse_cycle", 64'(cyc), 64'(p.cyc));
        chk("pulse_stamp", stamp_counter, p.stamp);
        chk("pulse_count", {32'd0, pkt_count}, {32'd0, p.pc});
      end
    end
  end

  // Drive one cycle of inputs, advance the model to the state after the coming edge.
  task automatic step(input bit rst, input bit v, input bit r, input bit l,
                      input bit iw, input logic [31:0] iv,
                      input bit ld, input logic [63:0] lv, input bit p);
    cyc_t   e;
    pulse_t pe;
    bit     start;
    reset = rst; s_axis_tvalid = v; s_axis_tready = r; s_axis_tlast = l;
    stamp_inc_wr = iw; stamp_inc = iv; stamp_load = ld; stamp_load_value = lv; pps = p;
    if (rst) begin
      m_cnt = 64'd0; m_inc = DEF_INC; m_open = 1'b0; m_pc = 32'd0; start = 1'b0;
    end else begin
      start = v && r && !m_open;
      if (v && r) m_open = !l;
      if (start) m_pc = m_pc + 32'd1;
      if (ld) m_cnt = lv;
`ifdef RX_STAMP_PPS_SYNC_EN
      else if (p) m_cnt = ((m_cnt + 64'h8000_0000) >> 32) << 32;
`endif
      else m_cnt = m_cnt + 64'(m_inc);
      if (iw) m_inc = iv;
    end
    e.cnt = m_cnt; e.pc = m_pc; e.ps = start;
    sq.push_back(e);
    if (start) begin
      pe.cyc = cyc + 1; pe.stamp = m_cnt; pe.pc = m_pc;
      pq.push_back(pe);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'd0, 0, 64'd0, 0);
  endtask

  task automatic beat(input bit v, input bit r, input bit l);
    step(0, v, r, l, 0, 32'd0, 0, 64'd0, 0);
  endtask

  initial begin
    reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tready = 1'b0; s_axis_tlast = 1'b0;
    stamp_inc_wr = 1'b0; stamp_inc = '0; stamp_load = 1'b0; stamp_load_value = '0; pps = 1'b0;

    step(1, 0, 0, 0, 0, 32'd0, 0, 64'd0, 0);
    step(1, 0, 0, 0, 0, 32'd0, 0, 64'd0, 0);
    chk("reset_counter", stamp_counter, 64'd0);
    chk("reset_count", {32'd0, pkt_count}, 64'd0);
    chk("reset_start", {63'd0, pkt_start}, 64'd0);

    idle(10);
    chk("idle10_counter", stamp_counter, 64'd268435460);
    chk("idle10_start", {63'd0, pkt_start}, 64'd0);

    // Three-beat packet with tready dropped for two cycles in the middle.
    beat(1, 1, 0);
    chk("stall_pkt_start", {63'd0, pkt_start}, 64'd1);
    beat(1, 0, 0);
    chk("stall_no_pulse0", {63'd0, pkt_start}, 64'd0);
    beat(1, 0, 1);
    beat(1, 1, 0);
    beat(1, 1, 1);
    chk("stall_no_pulse1", {63'd0, pkt_start}, 64'd0);
    chk("stall_count", {32'd0, pkt_count}, 64'd1);

    for (int i = 0; i < 4; i++) begin
      beat(1, 1, 1);
      chk("single_beat_pulse", {63'd0, pkt_start}, 64'd1);
    end
    idle(1);
    chk("single_beat_start_low", {63'd0, pkt_start}, 64'd0);
    chk("single_beat_count", {32'd0, pkt_count}, 64'd5);

    step(0, 0, 0, 0, 1, 32'd16, 1, 64'hFFFF_FFFF_FFFF_FFF0, 0);
    chk("load_value", stamp_counter, 64'hFFFF_FFFF_FFFF_FFF0);
    idle(1);
    chk("load_wrap", stamp_counter, 64'd0);
    idle(1);
    chk("load_after_wrap", stamp_counter, 64'd16);

`ifdef RX_STAMP_PPS_SYNC_EN
    step(0, 0, 0, 0, 0, 32'd0, 1, 64'h0000_0005_8000_0000, 0);
    step(0, 0, 0, 0, 0, 32'd0, 0, 64'd0, 1);
    chk("pps_round_up", stamp_counter, 64'h0000_0006_0000_0000);
    step(0, 0, 0, 0, 0, 32'd0, 1, 64'h0000_0005_7FFF_FFFF, 0);
    step(0, 0, 0, 0, 0, 32'd0, 0, 64'd0, 1);
    chk("pps_round_down", stamp_counter, 64'h0000_0005_0000_0000);
`endif

    // Reset lands on beat 2 of a 4-beat packet; beat 3 is then a new SOF.
    beat(1, 1, 0);
    step(1, 1, 1, 0, 0, 32'd0, 0, 64'd0, 0);
    chk("midpkt_reset_count", {32'd0, pkt_count}, 64'd0);
    beat(1, 1, 0);
    chk("midpkt_resof_pulse", {63'd0, pkt_start}, 64'd1);
    chk("midpkt_resof_count", {32'd0, pkt_count}, 64'd1);
    beat(1, 1, 1);
    chk("midpkt_last_no_pulse", {63'd0, pkt_start}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199) == 0,
           $urandom_range(9) < 7, $urandom_range(9) < 7, $urandom_range(9) < 3,
           $urandom_range(49) == 0, $urandom,
           $urandom_range(49) == 0, {$urandom, $urandom},
           $urandom_range(49) == 0);
    end

    @(negedge clk);
    #1;
    chk("cycle_queue_drained", 64'(sq.size()), 64'd0);
    chk("pulse_queue_drained", 64'(pq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
